reaction_session: RTL and testbench
===================================

// Module: reaction_session
// PURPOSE
//  Sequences the reaction-timer core through a fixed multi-round session: arms each trial, gates the user stop
//  button, and flags false starts (stop before stimulus). Enforces a response timeout and aggregates per-round
//  results into best and average. Sits between the debounced button pulses and the reaction core; drives the display.
// PARAMETERS
//  CLK_PERIOD_NS  10    clock period, sets ms tick divisor (1_000_000/CLK_PERIOD_NS cycles per ms)
//  ROUNDS_LOG2    2     session length = 2**ROUNDS_LOG2 rounds (1..4 allowed)
//  TIMEOUT_MS     1000  max recorded reaction; core force-stopped at this value
//  PENALTY_MS     1000  value recorded for a false-start round
//  GAP_MS         1000  inter-round pause
// PORTS
//  i_clk            in   1   clock
//  i_rst            in   1   reset, synchronous, active-high
//  i_start          in   1   start pulse (1 cycle, from debouncer edge detect)
//  i_stop           in   1   stop pulse (1 cycle)
//  i_clear          in   1   abort/clear pulse (1 cycle)
//  i_core_led       in   1   core stimulus LED (high = core in react phase)
//  i_core_val       in   14  core elapsed reaction ms
//  o_core_start     out  1   core start request (level)
//  o_core_stop      out  1   core stop (combinational)
//  o_core_clear     out  1   core clear pulse
//  o_display_val    out  14  binary value to display
//  o_display_greeting out 1  display "HI"
//  o_false_start    out  1   current/last round was a false start
//  o_round          out  3   rounds completed, 0..2**ROUNDS_LOG2
//  o_summary_best   out  1   in SUMMARY: 1 = showing best, 0 = average
//  o_done           out  1   session complete (SUMMARY state)
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except o_display_greeting=1; sum=0, best=14'h3FFF, round=0, ms counter=0.
//  States: IDLE, WAIT, REACT, GAP, SUMMARY.
//  IDLE: greeting=1. i_start -> clear sum/best/round/false_start, WAIT.
//  WAIT: o_core_start=1 every cycle (covers rand_gen not ready; harmless once core left idle);
//   display=i_core_val. i_core_led=1 -> REACT (i_stop same cycle forwarded as o_core_stop, not a false start).
//   i_stop & !i_core_led -> record PENALTY_MS, o_false_start=1, -> GAP.
//  REACT: display=i_core_val; o_core_stop=i_stop | (i_core_val>=TIMEOUT_MS).
//   First cycle with i_core_led=0 -> record min(i_core_val,TIMEOUT_MS), -> GAP.
//  Record (single cycle): sum+=rec; best=min(best,rec); round+=1; last=rec.
//  GAP: o_core_clear=1 on entry cycle only; ms counter cleared on entry; display=last; after GAP_MS ticks:
//   round==2**ROUNDS_LOG2 -> SUMMARY, else clear o_false_start, -> WAIT.
//  SUMMARY: o_done=1; display = best if o_summary_best else sum>>ROUNDS_LOG2 (truncating);
//   i_start toggles o_summary_best; start does not restart session.
//  i_clear (any non-IDLE state): o_core_clear=1 that cycle, -> IDLE, stats cleared; priority over all other
//   events. i_rst has priority over i_clear.
//  Widths: sum 14+ROUNDS_LOG2 bits, no overflow (rec<=max(TIMEOUT_MS,PENALTY_MS)<16384). Best holds a
//   false-start penalty if all rounds false-started.
//  o_round saturates at 2**ROUNDS_LOG2; no wrap. Stop pulses in IDLE/GAP/SUMMARY ignored.
//  Latency: stop -> core stop 0 cycles (REACT); result recorded 1 cycle after core LED falls.
// STRUCTURE
//  reaction_pkg: t_session_state enum, MAX_VAL14 = 14'h3FFF, MS_CYCLES(CLK_PERIOD_NS) function.
//  Sub-module ms_ticker (i_clk, i_rst, i_clear, o_tick): 1-cycle pulse per ms, counter reset by i_clear.
//  Top: one state register block, one next-state/output always_comb, stats registers.
// TESTING (bench core model or real reaction core; CLK_PERIOD_NS=100_000 -> 10 cycles/ms)
//  4 clean rounds, stop at 200/300/250/350 ms -> o_round 1..4, o_done=1, avg 275, toggle start -> best 200.
//  Stop while i_core_led=0 in round 2 -> o_false_start=1, 1000 recorded, core cleared, round 3 arms after GAP_MS.
//  No stop in REACT -> o_core_stop asserts at i_core_val=1000, 1000 recorded.
//  i_stop coincident with i_core_led rise -> o_core_stop same cycle, recorded 0, o_false_start=0.
//  i_clear mid-REACT round 3 -> o_core_clear=1, IDLE, greeting=1, o_round=0; restart -> fresh stats.
//  i_rst in GAP -> all outputs at reset values next cycle; i_stop in IDLE/SUMMARY -> no output change.

Source files
------------

// File: rtl/reaction_pkg.sv
`default_nettype none
// =============================================================================
// Module      : reaction_pkg
// Description : Shared state encoding, constants and ms divisor helper
// Revision    : 1.0 - initial release
// =============================================================================
package reaction_pkg;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WAIT    = 3'd1,
        S_REACT   = 3'd2,
        S_GAP     = 3'd3,
        S_SUMMARY = 3'd4
    } t_session_state;

    localparam logic [13:0] MAX_VAL14 = 14'h3FFF;

    function automatic int MS_CYCLES(input int clk_period_ns);
        int cycles;
        cycles = 1_000_000 / clk_period_ns;
        return (cycles < 1) ? 1 : cycles;
    endfunction

endpackage
`default_nettype wire

// File: rtl/reaction_session_ms_ticker.sv
`default_nettype none
// =============================================================================
// Module      : ms_ticker
// Description : One-cycle pulse per millisecond; phase restarted by i_clear
// Revision    : 1.0 - initial release
// =============================================================================
module ms_ticker #(
    parameter int CYCLES_PER_MS = 100_000
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int            CW     = (CYCLES_PER_MS > 1) ? $clog2(CYCLES_PER_MS) : 1;
    localparam logic [CW-1:0] c_last = CW'(CYCLES_PER_MS - 1);

    logic [CW-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_last) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_tick = (r_cnt == c_last) && !i_clear;

endmodule
`default_nettype wire

// File: rtl/reaction_session.sv
`default_nettype none
// =============================================================================
// Module      : reaction_session
// Description : Multi-round reaction session sequencer with false-start,
//               timeout handling and best/average aggregation
// Revision    : 1.0 - initial release
// =============================================================================
module reaction_session
    import reaction_pkg::*;
#(
    parameter int CLK_PERIOD_NS = 10,
    parameter int ROUNDS_LOG2   = 2,
    parameter int TIMEOUT_MS    = 1000,
    parameter int PENALTY_MS    = 1000,
    parameter int GAP_MS        = 1000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic        i_stop,
    input  logic        i_clear,
    input  logic        i_core_led,
    input  logic [13:0] i_core_val,
    output logic        o_core_start,
    output logic        o_core_stop,
    output logic        o_core_clear,
    output logic [13:0] o_display_val,
    output logic        o_display_greeting,
    output logic        o_false_start,
    output logic [2:0]  o_round,
    output logic        o_summary_best,
    output logic        o_done
);

    localparam int            SW        = 14 + ROUNDS_LOG2;
    localparam int            RW        = ROUNDS_LOG2 + 1;
    localparam int            GW        = $clog2(GAP_MS + 1);
    localparam logic [13:0]   c_timeout = 14'(TIMEOUT_MS);
    localparam logic [13:0]   c_penalty = 14'(PENALTY_MS);
    localparam logic [RW-1:0] c_rounds  = RW'(2 ** ROUNDS_LOG2);
    localparam logic [GW-1:0] c_gap_end = GW'(GAP_MS - 1);

    t_session_state r_state, w_next;
    logic           r_gap_entry;
    logic [GW-1:0]  r_gap_cnt;
    logic [SW-1:0]  r_sum;
    logic [13:0]    r_best, r_last;
    logic [RW-1:0]  r_round;
    logic           r_false_start, r_summary_best;

    logic           w_tick, w_tick_clear, w_record, w_stats_clear;
    logic           w_false_set, w_false_clr, w_toggle;
    logic [13:0]    w_rec_val;

    // Ticker phase is restarted on GAP entry so the pause is measured from there
    assign w_tick_clear = (r_state != S_GAP) || r_gap_entry;

    ms_ticker #(
        .CYCLES_PER_MS (MS_CYCLES(CLK_PERIOD_NS))
    ) u_ms_ticker (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_clear (w_tick_clear),
        .o_tick  (w_tick)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_gap_entry <= 1'b0;
            r_gap_cnt   <= '0;
        end else begin
            r_state     <= w_next;
            r_gap_entry <= (w_next == S_GAP) && (r_state != S_GAP);
            if (w_tick_clear) begin
                r_gap_cnt <= '0;
            end else if (w_tick) begin
                r_gap_cnt <= r_gap_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next             = r_state;
        o_core_start       = 1'b0;
        o_core_stop        = 1'b0;
        o_core_clear       = 1'b0;
        o_display_val      = '0;
        o_display_greeting = 1'b0;
        w_record           = 1'b0;
        w_rec_val          = '0;
        w_false_set        = 1'b0;
        w_false_clr        = 1'b0;
        w_stats_clear      = 1'b0;
        w_toggle           = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_display_greeting = 1'b1;
                if (i_start) begin
                    w_stats_clear = 1'b1;
                    w_next        = S_WAIT;
                end
            end
            S_WAIT: begin
                o_core_start  = 1'b1;
                o_display_val = i_core_val;
                if (i_core_led) begin
                    o_core_stop = i_stop;
                    w_next      = S_REACT;
                end else if (i_stop) begin
                    w_record    = 1'b1;
                    w_rec_val   = c_penalty;
                    w_false_set = 1'b1;
                    w_next      = S_GAP;
                end
            end
            S_REACT: begin
                o_display_val = i_core_val;
                o_core_stop   = i_stop || (i_core_val >= c_timeout);
                if (!i_core_led) begin
                    w_record  = 1'b1;
                    w_rec_val = (i_core_val > c_timeout) ? c_timeout : i_core_val;
                    w_next    = S_GAP;
                end
            end
            S_GAP: begin
                o_display_val = r_last;
                o_core_clear  = r_gap_entry;
                if (!r_gap_entry && w_tick && (r_gap_cnt == c_gap_end)) begin
                    if (r_round == c_rounds) begin
                        w_next = S_SUMMARY;
                    end else begin
                        w_false_clr = 1'b1;
                        w_next      = S_WAIT;
                    end
                end
            end
            S_SUMMARY: begin
                o_display_val = r_summary_best ? r_best : r_sum[ROUNDS_LOG2 +: 14];
                w_toggle      = i_start;
            end
            default: w_next = S_IDLE;
        endcase
        // Abort overrides every other event outside IDLE
        if (i_clear && (r_state != S_IDLE)) begin
            w_next        = S_IDLE;
            o_core_start  = 1'b0;
            o_core_stop   = 1'b0;
            o_core_clear  = 1'b1;
            w_record      = 1'b0;
            w_false_set   = 1'b0;
            w_false_clr   = 1'b0;
            w_toggle      = 1'b0;
            w_stats_clear = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || w_stats_clear) begin
            r_sum          <= '0;
            r_best         <= MAX_VAL14;
            r_last         <= '0;
            r_round        <= '0;
            r_false_start  <= 1'b0;
            r_summary_best <= 1'b0;
        end else begin
            if (w_record) begin
                r_sum  <= r_sum + SW'(w_rec_val);
                r_best <= (w_rec_val < r_best) ? w_rec_val : r_best;
                r_last <= w_rec_val;
                if (r_round != c_rounds) begin
                    r_round <= r_round + 1'b1;
                end
            end
            if (w_false_set) begin
                r_false_start <= 1'b1;
            end else if (w_false_clr) begin
                r_false_start <= 1'b0;
            end
            if (w_toggle) begin
                r_summary_best <= !r_summary_best;
            end
        end
    end

    generate
        if (RW <= 3) begin : g_round_narrow
            assign o_round = 3'(r_round);
        end else begin : g_round_wide
            assign o_round = (r_round > RW'(7)) ? 3'd7 : r_round[2:0];
        end
    endgenerate

    assign o_false_start  = r_false_start;
    assign o_summary_best = r_summary_best;
    assign o_done         = (r_state == S_SUMMARY);

endmodule
`default_nettype wire

// File: tb/tb_reaction_session.sv
`default_nettype none
// =============================================================================
// Module      : tb_reaction_session
// Description : Directed self-checking bench for reaction_session
// Revision    : 1.0 - initial release
// =============================================================================
module tb_reaction_session;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, stop = 1'b0, clr = 1'b0, led = 1'b0;
    logic [13:0] val = '0;
    logic        core_start, core_stop, core_clear, greeting, false_start, summary_best, done;
    logic [13:0] display;
    logic [2:0]  round;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    reaction_session #(
        .CLK_PERIOD_NS (100_000),
        .ROUNDS_LOG2   (2),
        .TIMEOUT_MS    (1000),
        .PENALTY_MS    (1000),
        .GAP_MS        (3)
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_start            (start),
        .i_stop             (stop),
        .i_clear            (clr),
        .i_core_led         (led),
        .i_core_val         (val),
        .o_core_start       (core_start),
        .o_core_stop        (core_stop),
        .o_core_clear       (core_clear),
        .o_display_val      (display),
        .o_display_greeting (greeting),
        .o_false_start      (false_start),
        .o_round            (round),
        .o_summary_best     (summary_best),
        .o_done             (done)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        cyc(1);
        start = 1'b0;
    endtask

    // Leaves the GAP pause; fails if neither WAIT nor SUMMARY appears in time
    task automatic wait_gap_exit(input string name);
        int n;
        n = 0;
        while (!core_start && !done && n < 500) begin
            cyc(1);
            n++;
        end
        checks++;
        if (!core_start && !done) begin
            failures++;
            $display("FAIL %s gap_exit_timeout: start=%0b done=%0b required one of them 1", name, core_start, done);
        end
    endtask

    // One clean round from WAIT: LED rises, user stops at rt ms, LED falls
    task automatic clean_round(input logic [13:0] rt, input logic [2:0] exp_round, input string name);
        led = 1'b1; val = 14'd0;
        cyc(1);
        val = rt; stop = 1'b1;
        #1;
        checks++;
        if (core_stop !== 1'b1) begin
            failures++;
            $display("FAIL %s core_stop: got %0b required 1", name, core_stop);
        end
        cyc(1);
        stop = 1'b0; led = 1'b0;
        cyc(1);
        checks++;
        if (core_clear !== 1'b1 || display !== rt || round !== exp_round || false_start !== 1'b0) begin
            failures++;
            $display("FAIL %s gap_entry: clear=%0b disp=%0d round=%0d fs=%0b required 1/%0d/%0d/0",
                     name, core_clear, display, round, false_start, rt, exp_round);
        end
        wait_gap_exit(name);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cyc(3);
        rst = 1'b0;
        #1;
        checks++;
        if (greeting !== 1'b1 || done !== 1'b0 || round !== 3'd0 || display !== 14'd0 ||
            core_start !== 1'b0 || core_stop !== 1'b0 || core_clear !== 1'b0 ||
            false_start !== 1'b0 || summary_best !== 1'b0) begin
            failures++;
            $display("FAIL reset: greet=%0b done=%0b round=%0d disp=%0d cs=%0b cst=%0b cc=%0b fs=%0b sb=%0b required 1/0/0/0/0/0/0/0/0",
                     greeting, done, round, display, core_start, core_stop, core_clear, false_start, summary_best);
        end
    endtask

    task automatic test_idle_stop();
        stop = 1'b1;
        #1;
        checks++;
        if (core_stop !== 1'b0 || greeting !== 1'b1) begin
            failures++;
            $display("FAIL idle_stop: core_stop=%0b greet=%0b required 0/1", core_stop, greeting);
        end
        cyc(1);
        stop = 1'b0;
        checks++;
        if (greeting !== 1'b1 || round !== 3'd0 || core_start !== 1'b0) begin
            failures++;
            $display("FAIL idle_stop_after: greet=%0b round=%0d cs=%0b required 1/0/0", greeting, round, core_start);
        end
    endtask

    task automatic test_clean_session();
        pulse_start();
        checks++;
        if (core_start !== 1'b1 || greeting !== 1'b0) begin
            failures++;
            $display("FAIL clean_arm: cs=%0b greet=%0b required 1/0", core_start, greeting);
        end
        clean_round(14'd200, 3'd1, "clean_r1");
        clean_round(14'd300, 3'd2, "clean_r2");
        clean_round(14'd250, 3'd3, "clean_r3");
        clean_round(14'd350, 3'd4, "clean_r4");
        checks++;
        if (done !== 1'b1 || display !== 14'd275 || summary_best !== 1'b0 || round !== 3'd4) begin
            failures++;
            $display("FAIL clean_avg: done=%0b disp=%0d sb=%0b round=%0d required 1/275/0/4", done, display, summary_best, round);
        end
        pulse_start();
        checks++;
        if (summary_best !== 1'b1 || display !== 14'd200 || done !== 1'b1) begin
            failures++;
            $display("FAIL clean_best: sb=%0b disp=%0d done=%0b required 1/200/1", summary_best, display, done);
        end
        stop = 1'b1;
        cyc(1);
        stop = 1'b0;
        checks++;
        if (display !== 14'd200 || done !== 1'b1 || core_stop !== 1'b0 || summary_best !== 1'b1) begin
            failures++;
            $display("FAIL summary_stop: disp=%0d done=%0b cst=%0b sb=%0b required 200/1/0/1", display, done, core_stop, summary_best);
        end
        clr = 1'b1;
        #1;
        checks++;
        if (core_clear !== 1'b1) begin
            failures++;
            $display("FAIL summary_clear: core_clear=%0b required 1", core_clear);
        end
        cyc(1);
        clr = 1'b0;
    endtask

    task automatic test_false_start_timeout_coincident();
        pulse_start();
        clean_round(14'd400, 3'd1, "fs_r1");
        stop = 1'b1;
        #1;
        checks++;
        if (core_stop !== 1'b0) begin
            failures++;
            $display("FAIL false_start_stop: core_stop=%0b required 0", core_stop);
        end
        cyc(1);
        stop = 1'b0;
        checks++;
        if (false_start !== 1'b1 || core_clear !== 1'b1 || display !== 14'd1000 || round !== 3'd2) begin
            failures++;
            $display("FAIL false_start: fs=%0b cc=%0b disp=%0d round=%0d required 1/1/1000/2", false_start, core_clear, display, round);
        end
        wait_gap_exit("fs_gap");
        checks++;
        if (false_start !== 1'b0 || core_start !== 1'b1) begin
            failures++;
            $display("FAIL false_start_rearm: fs=%0b cs=%0b required 0/1", false_start, core_start);
        end
        // Round 3: user never stops, timeout must force the core
        led = 1'b1; val = 14'd0;
        cyc(1);
        val = 14'd999;
        #1;
        checks++;
        if (core_stop !== 1'b0) begin
            failures++;
            $display("FAIL timeout_999: core_stop=%0b required 0", core_stop);
        end
        val = 14'd1000;
        #1;
        checks++;
        if (core_stop !== 1'b1) begin
            failures++;
            $display("FAIL timeout_1000: core_stop=%0b required 1", core_stop);
        end
        cyc(1);
        val = 14'd1003; led = 1'b0;
        cyc(1);
        checks++;
        if (display !== 14'd1000 || round !== 3'd3) begin
            failures++;
            $display("FAIL timeout_rec: disp=%0d round=%0d required 1000/3", display, round);
        end
        wait_gap_exit("to_gap");
        // Round 4: stop lands on the LED rise
        led = 1'b1; stop = 1'b1; val = 14'd0;
        #1;
        checks++;
        if (core_stop !== 1'b1) begin
            failures++;
            $display("FAIL coincident_stop: core_stop=%0b required 1", core_stop);
        end
        cyc(1);
        stop = 1'b0; led = 1'b0;
        cyc(1);
        checks++;
        if (display !== 14'd0 || false_start !== 1'b0 || round !== 3'd4) begin
            failures++;
            $display("FAIL coincident_rec: disp=%0d fs=%0b round=%0d required 0/0/4", display, false_start, round);
        end
        wait_gap_exit("co_gap");
        checks++;
        if (done !== 1'b1 || display !== 14'd600) begin
            failures++;
            $display("FAIL fs_avg: done=%0b disp=%0d required 1/600", done, display);
        end
        pulse_start();
        checks++;
        if (display !== 14'd0) begin
            failures++;
            $display("FAIL fs_best: disp=%0d required 0", display);
        end
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    task automatic test_clear_mid_react();
        pulse_start();
        clean_round(14'd100, 3'd1, "cl_r1");
        clean_round(14'd200, 3'd2, "cl_r2");
        led = 1'b1; val = 14'd0;
        cyc(1);
        val = 14'd50; clr = 1'b1;
        #1;
        checks++;
        if (core_clear !== 1'b1) begin
            failures++;
            $display("FAIL clear_react: core_clear=%0b required 1", core_clear);
        end
        cyc(1);
        clr = 1'b0; led = 1'b0; val = 14'd0;
        checks++;
        if (greeting !== 1'b1 || round !== 3'd0 || done !== 1'b0 || display !== 14'd0) begin
            failures++;
            $display("FAIL clear_idle: greet=%0b round=%0d done=%0b disp=%0d required 1/0/0/0", greeting, round, done, display);
        end
        pulse_start();
        clean_round(14'd120, 3'd1, "re_r1");
        clean_round(14'd120, 3'd2, "re_r2");
        clean_round(14'd120, 3'd3, "re_r3");
        clean_round(14'd120, 3'd4, "re_r4");
        checks++;
        if (done !== 1'b1 || display !== 14'd120 || summary_best !== 1'b0) begin
            failures++;
            $display("FAIL restart_avg: done=%0b disp=%0d sb=%0b required 1/120/0", done, display, summary_best);
        end
        clr = 1'b1;
        cyc(1);
        clr = 1'b0;
    endtask

    task automatic test_rst_in_gap();
        pulse_start();
        led = 1'b1; val = 14'd0;
        cyc(1);
        stop = 1'b1; val = 14'd77;
        cyc(1);
        stop = 1'b0; led = 1'b0;
        cyc(1);
        checks++;
        if (display !== 14'd77 || round !== 3'd1) begin
            failures++;
            $display("FAIL rst_pre_gap: disp=%0d round=%0d required 77/1", display, round);
        end
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        #1;
        checks++;
        if (greeting !== 1'b1 || round !== 3'd0 || display !== 14'd0 || core_clear !== 1'b0 ||
            false_start !== 1'b0 || done !== 1'b0 || core_start !== 1'b0) begin
            failures++;
            $display("FAIL rst_gap: greet=%0b round=%0d disp=%0d cc=%0b fs=%0b done=%0b cs=%0b required 1/0/0/0/0/0/0",
                     greeting, round, display, core_clear, false_start, done, core_start);
        end
    endtask

    initial begin
        test_reset();
        test_idle_stop();
        test_clean_session();
        test_false_start_timeout_coincident();
        test_clear_mid_react();
        test_rst_in_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
